// File: rtl/iic_seq_engine.sv
// ----------------------------------------------------------------------------
// iic_seq_engine
//   ROM-scripted I2C register sequencer driving a basic_iic master. Each 32-bit
//   instruction word is fetched from an external synchronous ROM (one cycle of
//   read latency) and executed as a write, masked read-modify-write,
//   poll-until-match, timed wait, save or restore.
//
//   Instruction word: [31:28] op, [27:24] reserved, [23:16] reg, [15:8] val,
//                     [7:0] mask
//   Opcodes: 0 END, 1 WRITE/RMW, 2 POLL, 3 WAIT, 4 SAVE, 5 RESTORE, others illegal.
//
// Ports
//   CLK, RSTn   clock, asynchronous active-low reset
//   start       1-cycle pulse, run the script from address 0 (ignored while busy)
//   busy        script executing
//   done        script reached END; held until next start
//   error       script aborted; held until next start
//   err_code    1 poll timeout, 2 illegal opcode, 3 ROM overrun
//   err_pc      address of the faulting instruction
//   rom_addr    instruction address (rom_data valid one cycle later)
//   rom_data    instruction word from ROM
//   iic_cmd     00 nop, 01 write, 10 read (non-nop for one cycle)
//   iic_addr    register address for basic_iic
//   iic_wdata   write data for basic_iic
//   iic_rdata   read data, valid with iic_done
//   iic_done    1-cycle completion pulse from basic_iic
//
// Handshake with basic_iic: iic_cmd is non-zero for exactly one cycle (the
// *_GO state) with iic_addr/iic_wdata already stable; both are held unchanged
// until iic_done is seen in the matching *_WT state, and no further command is
// issued before that. iic_done arriving in any other state is ignored.
// ----------------------------------------------------------------------------
module iic_seq_engine #(
  parameter int ROM_AW     = 9,
  parameter int WAIT_UNIT  = 50000,
  parameter int POLL_LIMIT = 1000,
  parameter bit AUTO_START = 1'b1
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [ROM_AW-1:0] err_pc,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic [1:0]        iic_cmd,
  output logic [7:0]        iic_addr,
  output logic [7:0]        iic_wdata,
  input  logic [7:0]        iic_rdata,
  input  logic              iic_done
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_LATCH, S_RD_GO, S_RD_WT,
    S_WR_GO, S_WR_WT, S_WAIT, S_DONE, S_ERR
  } state_t;

  localparam logic [3:0] OP_END     = 4'd0;
  localparam logic [3:0] OP_WRITE   = 4'd1;
  localparam logic [3:0] OP_POLL    = 4'd2;
  localparam logic [3:0] OP_WAIT    = 4'd3;
  localparam logic [3:0] OP_SAVE    = 4'd4;
  localparam logic [3:0] OP_RESTORE = 4'd5;

  localparam logic [1:0] ERR_POLL    = 2'd1;
  localparam logic [1:0] ERR_ILLEGAL = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  localparam logic [ROM_AW-1:0] PC_MAX   = '1;
  localparam logic [31:0]       PRE_LAST = 32'(WAIT_UNIT - 1);
  localparam logic [15:0]       POLL_LAST = 16'(POLL_LIMIT - 1);

  state_t            state, state_nxt;
  logic [ROM_AW-1:0] pc;
  logic [3:0]        op_q;
  logic [7:0]        val_q, mask_q, scratch;
  logic [15:0]       poll_cnt, wait_cnt;
  logic [31:0]       pre_cnt;
  logic              auto_pend;

  // Fields of the word presented by the ROM during LATCH.
  logic [3:0] rom_op;
  logic [7:0] rom_reg, rom_val, rom_mask;
  logic       rsvd_unused;
  assign rom_op      = rom_data[31:28];
  assign rom_reg     = rom_data[23:16];
  assign rom_val     = rom_data[15:8];
  assign rom_mask    = rom_data[7:0];
  assign rsvd_unused = ^rom_data[27:24];

  // Control decisions produced alongside the next state.
  logic       kick;      // accepted start (explicit or armed by reset)
  logic       adv;       // current instruction completed
  logic       err_go;
  logic [1:0] err_nxt;
  logic       load_wr;
  logic [7:0] wr_val;
  logic       poll_hit;
  logic       wait_last;

  assign poll_hit  = (iic_rdata & mask_q) == (val_q & mask_q);
  assign wait_last = (pre_cnt == PRE_LAST) && (wait_cnt == 16'd1);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    kick      = 1'b0;
    adv       = 1'b0;
    err_go    = 1'b0;
    err_nxt   = 2'd0;
    load_wr   = 1'b0;
    wr_val    = 8'h00;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start || auto_pend) begin
          kick      = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: state_nxt = S_LATCH;
      S_LATCH: begin
        case (rom_op)
          OP_END: state_nxt = S_DONE;
          OP_WRITE: begin
            if (rom_mask == 8'hFF) begin
              load_wr   = 1'b1;
              wr_val    = rom_val;
              state_nxt = S_WR_GO;
            end else begin
              state_nxt = S_RD_GO;
            end
          end
          OP_POLL, OP_SAVE: state_nxt = S_RD_GO;
          OP_WAIT: begin
            if ({rom_val, rom_mask} == 16'd0) adv = 1'b1;
            else                              state_nxt = S_WAIT;
          end
          OP_RESTORE: begin
            load_wr   = 1'b1;
            wr_val    = (scratch & rom_mask) | (rom_val & ~rom_mask);
            state_nxt = S_WR_GO;
          end
          default: begin
            err_go  = 1'b1;
            err_nxt = ERR_ILLEGAL;
          end
        endcase
      end
      S_RD_GO: state_nxt = S_RD_WT;
      S_RD_WT: begin
        if (iic_done) begin
          case (op_q)
            OP_WRITE: begin
              load_wr   = 1'b1;
              wr_val    = (iic_rdata & ~mask_q) | (val_q & mask_q);
              state_nxt = S_WR_GO;
            end
            OP_POLL: begin
              if (poll_hit) begin
                adv = 1'b1;
              end else if (poll_cnt == POLL_LAST) begin
                err_go  = 1'b1;
                err_nxt = ERR_POLL;
              end else begin
                state_nxt = S_RD_GO;
              end
            end
            default: adv = 1'b1;  // SAVE: scratch captured below
          endcase
        end
      end
      S_WR_GO: state_nxt = S_WR_WT;
      S_WR_WT: if (iic_done) adv = 1'b1;
      S_WAIT:  if (wait_last) adv = 1'b1;
      default: state_nxt = S_IDLE;
    endcase

    // The last ROM word must be END; pc is never allowed to wrap.
    if (adv) begin
      if (pc == PC_MAX) begin
        err_go  = 1'b1;
        err_nxt = ERR_OVERRUN;
      end else begin
        state_nxt = S_FETCH;
      end
    end
    if (err_go) state_nxt = S_ERR;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      pc        <= '0;
      op_q      <= 4'd0;
      val_q     <= 8'h00;
      mask_q    <= 8'h00;
      scratch   <= 8'h00;
      poll_cnt  <= 16'd0;
      wait_cnt  <= 16'd0;
      pre_cnt   <= 32'd0;
      err_code  <= 2'd0;
      err_pc    <= '0;
      iic_addr  <= 8'h00;
      iic_wdata <= 8'h00;
      auto_pend <= AUTO_START;
    end else begin
      // Auto-start is only offered in the first cycle after reset.
      auto_pend <= 1'b0;
      if (kick) begin
        pc       <= '0;
        err_code <= 2'd0;
      end
      if (state == S_LATCH) begin
        op_q     <= rom_op;
        iic_addr <= rom_reg;
        val_q    <= rom_val;
        mask_q   <= rom_mask;
        poll_cnt <= 16'd0;
        wait_cnt <= {rom_val, rom_mask};
        pre_cnt  <= 32'd0;
      end
      if (load_wr) iic_wdata <= wr_val;
      if (state == S_RD_WT && iic_done) begin
        if (op_q == OP_SAVE) scratch <= iic_rdata;
        if (op_q == OP_POLL) poll_cnt <= poll_cnt + 16'd1;
      end
      if (state == S_WAIT) begin
        if (pre_cnt == PRE_LAST) begin
          pre_cnt  <= 32'd0;
          wait_cnt <= wait_cnt - 16'd1;
        end else begin
          pre_cnt <= pre_cnt + 32'd1;
        end
      end
      if (adv && pc != PC_MAX) pc <= pc + ROM_AW'(1);
      if (err_go) begin
        err_code <= err_nxt;
        err_pc   <= pc;
      end
    end
  end

  assign rom_addr = pc;
  assign busy     = !(state == S_IDLE || state == S_DONE || state == S_ERR);
  assign done     = (state == S_DONE);
  assign error    = (state == S_ERR);
  assign iic_cmd  = (state == S_RD_GO) ? 2'b10 :
                    (state == S_WR_GO) ? 2'b01 : 2'b00;

endmodule

// File: tb/tb_iic_seq_engine.sv
// ----------------------------------------------------------------------------
// tb_iic_seq_engine
//   Directed bench for iic_seq_engine (ROM_AW=3, WAIT_UNIT=10, POLL_LIMIT=4).
//   A behavioural ROM and basic_iic model surround the DUT; every command the
//   model sees is logged and compared with a hand-built expected queue.
// ----------------------------------------------------------------------------
module tb_iic_seq_engine;

  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy, done, error;
  logic [1:0]    err_code;
  logic [AW-1:0] err_pc, rom_addr;
  logic [31:0]   rom_data;
  logic [1:0]    iic_cmd;
  logic [7:0]    iic_addr, iic_wdata, iic_rdata;
  logic          iic_done;

  iic_seq_engine #(
    .ROM_AW(AW), .WAIT_UNIT(10), .POLL_LIMIT(4), .AUTO_START(1'b1)
  ) dut (
    .CLK(clk), .RSTn(rst_n), .start(start), .busy(busy), .done(done),
    .error(error), .err_code(err_code), .err_pc(err_pc),
    .rom_addr(rom_addr), .rom_data(rom_data), .iic_cmd(iic_cmd),
    .iic_addr(iic_addr), .iic_wdata(iic_wdata), .iic_rdata(iic_rdata),
    .iic_done(iic_done)
  );

  // clock / reset
  always #5 clk = ~clk;

  // synchronous ROM, one cycle latency
  logic [31:0] rom [0:7];
  always @(posedge clk) rom_data <= rom[rom_addr];

  // basic_iic model: completes each command three cycles after the pulse
  logic [7:0]  mem [0:255];
  int          pend = 0;
  int          da_reads = 0;
  bit          poll_never = 1'b0;
  logic [7:0]  resp;
  logic [17:0] log_q[$];
  logic [17:0] exp_q[$];

  initial begin
    iic_done  = 1'b0;
    iic_rdata = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      iic_done = 1'b0;
      if (!rst_n) begin
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            iic_done  = 1'b1;
            iic_rdata = resp;
          end
        end
        if (iic_cmd == 2'b01) begin
          log_q.push_back({2'b01, iic_addr, iic_wdata});
          mem[iic_addr] = iic_wdata;
          pend = 2;
        end else if (iic_cmd == 2'b10) begin
          log_q.push_back({2'b10, iic_addr, 8'h00});
          if (iic_addr == 8'hDA) begin
            resp = (poll_never || da_reads >= 2) ? 8'h04 : 8'h00;
            if (!poll_never && da_reads < 2) resp = 8'h04;
            if (!poll_never && da_reads >= 2) resp = 8'h00;
            da_reads++;
          end else begin
            resp = mem[iic_addr];
          end
          pend = 2;
        end
      end
    end
  end

  // scoreboard and checks
  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_log(input string tag);
    int n;
    check({tag, " cmd count"}, 32'(log_q.size()), 32'(exp_q.size()));
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s cmd%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
    log_q.delete();
    exp_q.delete();
  endtask

  // driver tasks
  task automatic clear_rom();
    for (int i = 0; i < 8; i++) rom[i] = 32'h0000_0000;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk);
      if (done || error) got = 1'b1;
    end
    check({tag, " finished"}, 32'(got), 32'd1);
  endtask

  int n_edges;
  bit seen;

  initial begin
    start = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h1F] = 8'hA5;
    mem[8'hEB] = 8'h5A;

    // 1: single direct write, launched by auto-start
    clear_rom();
    rom[0] = 32'h10E6_10FF;
    repeat (3) @(negedge clk);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst error", 32'(error), 32'd0);
    check("rst rom_addr", 32'(rom_addr), 32'd0);
    check("rst iic_cmd", 32'(iic_cmd), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("auto start busy", 32'(busy), 32'd1);
    exp_q.push_back({2'b01, 8'hE6, 8'h10});
    wait_end("write");
    check("write done", 32'(done), 32'd1);
    check("write busy", 32'(busy), 32'd0);
    check("write error", 32'(error), 32'd0);
    check_log("write");

    // 2: read-modify-write, A5 -> (A5 & F0) | (0C & 0F) = AC
    clear_rom();
    rom[0] = 32'h101F_0C0F;
    exp_q.push_back({2'b10, 8'h1F, 8'h00});
    exp_q.push_back({2'b01, 8'h1F, 8'hAC});
    pulse_start();
    wait_end("rmw");
    check("rmw done", 32'(done), 32'd1);
    check_log("rmw");

    // 3a: poll DA for 00 under mask 15; model returns 04, 04, 00
    clear_rom();
    rom[0] = 32'h20DA_0015;
    da_reads = 0;
    poll_never = 1'b0;
    repeat (3) exp_q.push_back({2'b10, 8'hDA, 8'h00});
    pulse_start();
    wait_end("poll");
    check("poll done", 32'(done), 32'd1);
    check_log("poll");

    // 3b: poll never matches, placed at address 1 -> timeout after 4 reads
    clear_rom();
    rom[0] = 32'h3000_0000;
    rom[1] = 32'h20DA_0015;
    poll_never = 1'b1;
    repeat (4) exp_q.push_back({2'b10, 8'hDA, 8'h00});
    pulse_start();
    wait_end("poll timeout");
    check("poll to error", 32'(error), 32'd1);
    check("poll to err_code", 32'(err_code), 32'd1);
    check("poll to err_pc", 32'(err_pc), 32'd1);
    check("poll to busy", 32'(busy), 32'd0);
    check_log("poll timeout");

    // 4: WAIT {00,03} x 10 cycles; start edge counts as edge 1, LATCH ends on
    //    edge 3, so pc steps to 1 on edge 33
    clear_rom();
    rom[0] = 32'h3000_0003;
    @(negedge clk) start = 1'b1;
    n_edges = 0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk);
      #1;
      n_edges++;
      if (n_edges == 1) begin
        start = 1'b0;
        check("restart clears error", 32'(error), 32'd0);
        check("restart clears err_code", 32'(err_code), 32'd0);
      end
      if (rom_addr == 3'd1) seen = 1'b1;
    end
    check("wait reached next fetch", 32'(seen), 32'd1);
    check("wait duration window", 32'(n_edges >= 31 && n_edges <= 35), 32'd1);
    wait_end("wait");
    check("wait done", 32'(done), 32'd1);
    check_log("wait");

    // 4b: illegal opcode 7
    clear_rom();
    rom[0] = 32'h7000_0000;
    pulse_start();
    wait_end("illegal");
    check("illegal error", 32'(error), 32'd1);
    check("illegal err_code", 32'(err_code), 32'd2);
    check("illegal err_pc", 32'(err_pc), 32'd0);

    // 5: save EB (5A), restore into 2D with val 00 mask FF; stray start mid-run
    clear_rom();
    rom[0] = 32'h40EB_0000;
    rom[1] = 32'h502D_00FF;
    exp_q.push_back({2'b10, 8'hEB, 8'h00});
    exp_q.push_back({2'b01, 8'h2D, 8'h5A});
    pulse_start();
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("busy start ignored busy", 32'(busy), 32'd1);
    wait_end("save restore");
    check("save restore done", 32'(done), 32'd1);
    check_log("save restore");

    // 6: no END in an 8-word ROM -> overrun at address 7
    for (int i = 0; i < 8; i++) rom[i] = 32'h3000_0000;
    pulse_start();
    wait_end("overrun");
    check("overrun error", 32'(error), 32'd1);
    check("overrun err_code", 32'(err_code), 32'd3);
    check("overrun err_pc", 32'(err_pc), 32'd7);

    // reset in the middle of a write, then auto-start reruns the script
    clear_rom();
    rom[0] = 32'h10E6_10FF;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (iic_cmd == 2'b01) seen = 1'b1;
    end
    check("mid write cmd seen", 32'(seen), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort error", 32'(error), 32'd0);
    check("abort err_code", 32'(err_code), 32'd0);
    check("abort err_pc", 32'(err_pc), 32'd0);
    check("abort rom_addr", 32'(rom_addr), 32'd0);
    check("abort iic_cmd", 32'(iic_cmd), 32'd0);
    check("abort iic_addr", 32'(iic_addr), 32'd0);
    check("abort iic_wdata", 32'(iic_wdata), 32'd0);
    log_q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("rerun busy", 32'(busy), 32'd1);
    check("rerun rom_addr", 32'(rom_addr), 32'd0);
    exp_q.push_back({2'b01, 8'hE6, 8'h10});
    wait_end("rerun");
    check("rerun done", 32'(done), 32'd1);
    check_log("rerun");

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
